// File: rtl/bus_map_pkg.sv
// Shared types and the default address map for the CPU-side MMIO router.
package bus_map_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Index 0 is the rightmost element: data RAM, FPGA I/O, UART, video memory.
  localparam logic [3:0][19:0] DEF_BASE = {20'h003EB, 20'h10000, 20'h18000, 20'h20000};
  localparam logic [3:0][19:0] DEF_MASK = {20'hFFFFF, 20'hFFFFF, 20'hF8000, 20'hFFFFF};

endpackage

// File: rtl/region_match.sv
// Base/mask region compare; lowest matching index wins.
module region_match
  import bus_map_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] REGION_BASE = DEF_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] REGION_MASK = DEF_MASK
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [N_SLAVES-1:0] onehot
);

  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && ((addr & REGION_MASK[i]) == REGION_BASE[i])) begin
        hit       = 1'b1;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// CPU data port to N slave regions: decode, single outstanding access with
// ready timeout, one-cycle response pulse, sticky error address/count.
module mmio_router
  import bus_map_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] REGION_BASE = DEF_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] REGION_MASK = DEF_MASK,
  parameter int TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [N_SLAVES-1:0]          slv_sel,
  output logic [N_SLAVES-1:0]          slv_we,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata,
  input  logic [N_SLAVES-1:0]          slv_ready,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic                  hit;
  logic [N_SLAVES-1:0]   hit_oh;
  logic [N_SLAVES-1:0]   sel_q;
  logic                  wr_q;
  logic [TCNT_W-1:0]     tcnt;
  logic                  sel_ready, tmo_last, log_err;
  logic [DATA_W-1:0]     sel_rdata;

  region_match #(
    .ADDR_W     (ADDR_W),
    .N_SLAVES   (N_SLAVES),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_match (
    .addr  (req_addr),
    .hit   (hit),
    .onehot(hit_oh)
  );

  // Only the latched slave's ready and data are ever looked at.
  assign sel_ready = |(slv_ready & sel_q);
  assign tmo_last  = (tcnt == TCNT_W'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (sel_q[i]) sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    slv_sel   = '0;
    slv_we    = '0;
    log_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = hit ? ACCESS : RESP;
          log_err   = !hit;
        end
      end
      ACCESS: begin
        slv_sel = sel_q;
        slv_we  = sel_q & {N_SLAVES{wr_q}};
        if (sel_ready) begin
          state_nxt = RESP;
        end else if (tmo_last) begin
          state_nxt = RESP;
          log_err   = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_addr  <= '0;
      slv_wdata <= '0;
      wr_q      <= 1'b0;
      sel_q     <= '0;
      tcnt      <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        slv_addr  <= req_addr;
        slv_wdata <= req_wdata;
        wr_q      <= req_write;
        sel_q     <= hit_oh;
        tcnt      <= '0;
        if (!hit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == ACCESS) begin
        tcnt <= tcnt + TCNT_W'(1);
        if (sel_ready) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= wr_q ? '0 : sel_rdata;
        end else if (tmo_last) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (log_err) begin
        err_addr <= (state == IDLE) ? req_addr : slv_addr;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed plus randomized bench for mmio_router against a transaction-level model.
module tb_mmio_router;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  slv_sel, slv_we, slv_ready;
  logic [19:0] slv_addr, err_addr;
  logic [31:0] slv_wdata;
  logic [127:0] slv_rdata;
  logic [7:0]  err_cnt;

  logic [31:0] srd [4];
  int          dly [4];
  logic [3:0]  rdy_en;
  int          acc_cyc;

  int          n_assert = 0, n_fail = 0;
  int          exp_cnt = 0;
  logic [19:0] exp_eaddr = '0;

  always #5 clk = ~clk;

  mmio_router #(.ADDR_W(20), .DATA_W(32), .N_SLAVES(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  // Slave models: ready rises once the slave has been selected for dly[i] cycles.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)        acc_cyc <= 0;
    else if (|slv_sel) acc_cyc <= acc_cyc + 1;
    else               acc_cyc <= 0;

  always_comb begin
    slv_ready = '0;
    for (int i = 0; i < 4; i++) slv_ready[i] = rdy_en[i] && (acc_cyc >= dly[i]);
  end

  assign slv_rdata = {srd[3], srd[2], srd[1], srd[0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address map as ranges: RAM, FPGA I/O window, UART, video.
  function automatic int decode(input logic [19:0] a);
    if (a == 20'h20000) return 0;
    if (a >= 20'h18000 && a <= 20'h1FFFF) return 1;
    if (a == 20'h10000) return 2;
    if (a == 20'h003EB) return 3;
    return -1;
  endfunction

  task automatic do_req(input logic w, input logic [19:0] a, input logic [31:0] d);
    int idx, el, es, lat, selc;
    logic ee, got;
    logic [31:0] er;
    logic [3:0]  eoh;
    idx = decode(a);
    eoh = '0;
    if (idx < 0) begin
      el = 1; es = 0; ee = 1'b1; er = '0;
    end else begin
      eoh[idx] = 1'b1;
      if (rdy_en[idx] && dly[idx] <= TMO - 1) begin
        el = dly[idx] + 2; es = dly[idx] + 1; ee = 1'b0; er = w ? 32'h0 : srd[idx];
      end else begin
        el = TMO + 1; es = TMO; ee = 1'b1; er = '0;
      end
    end
    if (ee) begin
      if (exp_cnt < 255) exp_cnt++;
      exp_eaddr = a;
    end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Keep junk requests on the bus while busy; they must be ignored.
    req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
    lat = 0; selc = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("req_ready_busy", req_ready, 0);
      if (rsp_valid) begin
        got = 1'b1;
        req_valid = 1'b0;
      end else if (slv_sel != 4'b0) begin
        selc++;
        chk("slv_sel", slv_sel, eoh);
        chk("slv_we", slv_we, w ? eoh : 4'b0);
        chk("slv_addr", slv_addr, a);
        chk("slv_wdata", slv_wdata, d);
      end
    end
    req_valid = 1'b0;
    chk("rsp_seen", got, 1);
    chk("latency", lat, el);
    chk("sel_cycles", selc, es);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_rdata", rsp_rdata, er);
    chk("resp_sel_drop", {slv_sel, slv_we}, 8'h0);
    chk("err_cnt", err_cnt, exp_cnt);
    chk("err_addr", err_addr, exp_eaddr);
  endtask

  initial begin
    int cnt_rsp;
    logic [19:0] ra;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rdy_en = 4'hF;
    for (int i = 0; i < 4; i++) begin dly[i] = 0; srd[i] = $urandom; end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    chk("rst_slv", {slv_sel, slv_we, slv_addr, slv_wdata}, 60'h0);
    chk("rst_err", {err_addr, err_cnt}, 28'h0);
    rst_n = 1'b1;

    // Directed cases from the plan
    do_req(1'b1, 20'h20000, 32'hDEADBEEF);
    srd[1] = 32'h12345678; dly[1] = 3;
    do_req(1'b0, 20'h1ABCD, 32'h0);
    do_req(1'b0, 20'h00400, 32'h0);
    rdy_en[2] = 1'b0;
    do_req(1'b1, 20'h10000, 32'hCAFEF00D);
    rdy_en[2] = 1'b1; dly[2] = TMO - 1;   // ready on the last allowed cycle
    do_req(1'b0, 20'h10000, 32'h0);
    dly[3] = TMO;                          // one cycle too late
    do_req(1'b0, 20'h003EB, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        dly[i] = $urandom_range(0, 20);
        srd[i] = $urandom;
      end
      rdy_en = 4'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 20'h20000;
        1: ra = 20'h18000 | 20'($urandom_range(0, 32'h7FFF));
        2: ra = 20'h10000;
        3: ra = 20'h003EB;
        default: ra = 20'($urandom);
      endcase
      do_req(1'($urandom), ra, $urandom);
    end

    // Saturation of the error counter
    for (int t = 0; t < 300; t++) do_req(1'b0, 20'h00400 + 20'(t), 32'h0);
    chk("err_cnt_sat", err_cnt, 8'd255);

    // Reset in the second ACCESS cycle aborts the read
    rdy_en = 4'h0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h003EB;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    chk("abort_slv", {slv_sel, slv_we, slv_addr, slv_wdata}, 60'h0);
    chk("abort_err", {err_addr, err_cnt}, 28'h0);
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = 0; exp_eaddr = '0;
    cnt_rsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) cnt_rsp++;
    end
    chk("abort_no_rsp", cnt_rsp, 0);
    chk("abort_err_cnt", err_cnt, 0);
    rdy_en = 4'hF; dly[0] = 1; srd[0] = 32'hA5A55A5A;
    do_req(1'b0, 20'h20000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
